// File: rtl/ha_serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the serial half-adder adder.
// master: start, abort, a, b, cin out; busy, done, sum, cout in.
// slave: the mirror image, used by ha_serial_add_ctrl.
interface ha_serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/ha_serial_add_ctrl.sv
// Serial LSB-first adder: one bit per clock through two half adders
// and a carry flop, with start/abort/busy/done control.
// Ports: clk, rst (sync, active high), bus (slave side of
// ha_serial_add_ctrl_if: start, abort, a, b, cin -> busy, done, sum, cout).
module ha_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    ha_serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic s1;
    logic c1;
    logic s;
    logic c2;
    logic last;
    logic accept;
    logic step;

    // Bit-level cell: two cascaded half adders.
    always_comb begin
        s1 = a_sr[0] ^ b_sr[0];
        c1 = a_sr[0] & b_sr[0];
        s  = s1 ^ carry;
        c2 = s1 & carry;
    end

    // abort beats start in IDLE; in RUN it freezes the datapath.
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign step   = (state == RUN) && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = RUN;
            end
            RUN: begin
                if (bus.abort)  state_nx = IDLE;
                else if (last)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            psum  <= {s, psum[WIDTH-1:1]};
            carry <= c1 | c2;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= {s, psum[WIDTH-1:1]};
                cout_q <= c1 | c2;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Directed bench for ha_serial_add_ctrl with a result scoreboard.
// Expected {cout,sum} values are queued at start and popped at done.
module tb_ha_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    ha_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    ha_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Accept is sampled at the edge inside step().
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input bit push);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        if (push) sb.push_back(model(a, b, ci));
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic check_result(input string tag);
        logic [W:0] e;
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, e[W-1:0]});
            chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e[W]});
        end
    endtask

    task automatic no_done(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int bcnt;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // 1: reset from an arbitrary mid-operation state
        step();
        rst = 1'b0;
        issue(8'hC3, 8'h7E, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum", {24'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);

        // 2: single op, latency and busy length
        issue(8'h5A, 8'h33, 1'b0, 1'b1);
        bcnt = bus.busy ? 1 : 0;
        cyc  = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
            if (bus.busy) bcnt++;
        end
        chk("op1_latency", cyc, W);
        check_result("op1");
        step();
        chk("op1_busy_cycles", bcnt + (bus.busy ? 1 : 0), W + 1);
        chk("op1_idle_done", {31'd0, bus.done}, 32'd0);
        no_done("op1_hold_done", 3);
        chk("op1_hold_sum", {24'd0, bus.sum}, 32'h8D);

        // 4: start while busy is ignored, operands toggled in RUN
        issue(8'h5A, 8'h33, 1'b0, 1'b1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (cyc == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end else begin
                bus.start = 1'b0;
                bus.a     = ~bus.a;
                bus.b     = ~bus.b;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0;
        chk("op4_latency", cyc, W + 1);
        check_result("op4");
        no_done("op4_single_done", W + 4);

        // 5: abort mid-RUN, then start+abort in IDLE
        issue(8'h10, 8'h10, 1'b0, 1'b0);
        step();
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        no_done("abort_no_done", W + 2);
        chk("abort_sum", {24'd0, bus.sum}, 32'h8D);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        bus.abort = 1'b1;
        issue(8'h22, 8'h11, 1'b0, 1'b0);
        chk("sa_busy", {31'd0, bus.busy}, 32'd0);
        bus.abort = 1'b0;
        step();
        chk("sa_busy2", {31'd0, bus.busy}, 32'd0);

        // 3: carry chains, back to back with start held high
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        sb.push_back(model(8'hFF, 8'h01, 1'b0));
        step();
        bus.a   = 8'hFF;
        bus.b   = 8'hFF;
        bus.cin = 1'b1;
        sb.push_back(model(8'hFF, 8'hFF, 1'b1));
        wait_done(cyc);
        chk("cc1_latency", cyc, W);
        check_result("cc1");
        cyc = 0;
        step();
        cyc++;
        while (bus.done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        bus.start = 1'b0;
        chk("cc_period", cyc, W + 2);
        check_result("cc2");

        // 6: reset mid-RUN, then a fresh op
        step();
        issue(8'h55, 8'hAA, 1'b0, 1'b0);
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_sum", {24'd0, bus.sum}, 32'd0);
        chk("mrst_cout", {31'd0, bus.cout}, 32'd0);
        no_done("mrst_no_done", W + 2);
        issue(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done(cyc);
        chk("fresh_latency", cyc, W);
        check_result("fresh");
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ha_serial_add_ctrl.md
Name: ha_serial_add_ctrl

Overview:
Sequencer that reuses one bit-level adder cell, built from two half-adder stages plus a carry flop, to add two WIDTH-bit operands serially, LSB first, one bit per clock. It provides a start/busy/done handshake, a bit counter, and a registered result. It is the control layer above the half-adder datapath and trades area for latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request a new addition; sampled only in IDLE.
abort  input  1  cancel the operation in progress; sampled in RUN.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in; captured on accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  registered sum result.
cout  output  1  registered carry-out.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, partial-sum register, carry flop and bit counter are all cleared.
  - rst has priority over all other inputs, including mid-RUN and in DONE. No done pulse follows a reset.
- IDLE:
  - start=1 and abort=0 at edge T0: capture a, b into shift registers, carry<=cin, cnt<=0, go to RUN.
  - start=1 and abort=1 together: abort wins; stay in IDLE.
- RUN, each edge:
  - Half-adder 1: s1=a_sr[0]^b_sr[0], c1=a_sr[0]&b_sr[0].
  - Half-adder 2: s=s1^carry, c2=s1&carry.
  - carry<=c1|c2.
  - Partial sum shifts right with s inserted at MSB. a_sr and b_sr shift right with zero fill. cnt<=cnt+1.
  - Counter width is clog2(WIDTH); no wrap occurs within an operation.
- Completion: at the edge where cnt==WIDTH-1 (edge T_WIDTH):
  - sum<=final shifted partial sum; cout<=final carry; go to DONE.
  - sum/cout change only at this transition and otherwise hold their value.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally. start and abort are ignored in DONE.
- Abort in RUN: next state is IDLE, busy drops, no done pulse, sum/cout keep their previous values.
- start asserted while busy is ignored; it is not queued.
- Timing:
  - Latency: done is high in the cycle after edge T_WIDTH, i.e. WIDTH+1 cycles after the start-sampling edge.
  - Minimum issue period is WIDTH+2 cycles. With start held high, a new operation is accepted at the first IDLE edge after DONE.
- Operands are captured at start, so later changes to a, b or cin during RUN have no effect.

Test Plan:
1. Reset: assert rst 2 cycles from an arbitrary state -> busy=0, done=0, sum=0x00, cout=0.
2. WIDTH=8, a=0x5A, b=0x33, cin=0, start 1 cycle -> busy for 9 cycles; done pulses once, 9 cycles after the start edge; sum=0x8D, cout=0. Values hold in IDLE afterwards.
3. Carry chains, back-to-back with start held high:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - Next op: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
   - Second done arrives exactly 10 cycles after the first.
4. Busy rejection and operand stability: during the op from scenario 2, pulse start with a=0x01, b=0x01 at cycle 3, and toggle a/b every cycle -> single done; sum=0x8D, cout=0.
5. Abort at cycle 4 of an op with a=0x10, b=0x10 (previous result 0x8D/0) -> busy=0 next cycle; no done; sum=0x8D, cout=0 unchanged. start+abort together in IDLE -> stays IDLE.
6. Reset mid-RUN at cycle 5 -> next edge: busy=0, sum=0, cout=0; done never pulses. A fresh start afterwards gives a correct result (a=0x01, b=0x02 -> sum=0x03).
